// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: captures EX/MEM controls (S1), forms the write-back value from ALU or
// load data (S2). Defining LOAD_SIGN_EXT_EN enables signed byte/halfword load extension.
module mem_wb_stage #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_REG  = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic [NB_REG-1:0]  i_rd,
  input  logic               i_reg_write,
  input  logic               i_mem_to_reg,
  input  logic [1:0]         i_read_size,
  input  logic               i_load_signed,
  input  logic [NB_DATA-1:0] i_mem_data,
  input  logic               i_stall,
  input  logic               i_flush,
  output logic               o_wb_valid,
  output logic [NB_DATA-1:0] o_wb_data,
  output logic [NB_REG-1:0]  o_wb_rd,
  output logic               o_wb_reg_write,
  output logic               o_fwd_busy
);

  localparam logic [1:0] READ_DISABLE  = 2'd0;
  localparam logic [1:0] READ_BYTE     = 2'd1;
  localparam logic [1:0] READ_HALFWORD = 2'd2;
  localparam logic [1:0] READ_WORD     = 2'd3;

`ifdef LOAD_SIGN_EXT_EN
  localparam logic SIGN_EXT_EN = 1'b1;
`else
  localparam logic SIGN_EXT_EN = 1'b0;
`endif

  logic               s1_valid;
  logic [NB_DATA-1:0] s1_alu_result;
  logic [NB_REG-1:0]  s1_rd;
  logic               s1_reg_write;
  logic               s1_mem_to_reg;
  logic [1:0]         s1_read_size;
  logic               s1_load_signed;

  logic               s1_live;
  logic               byte_sign;
  logic               half_sign;
  logic [NB_DATA-1:0] wb_value;

  // A flushed S1 instruction never reaches S2
  assign s1_live   = s1_valid & ~i_flush;
  assign byte_sign = SIGN_EXT_EN & s1_load_signed & i_mem_data[7];
  assign half_sign = SIGN_EXT_EN & s1_load_signed & i_mem_data[15];

  always_comb begin
    wb_value = '0;
    if (!s1_mem_to_reg) begin
      wb_value = s1_alu_result;
    end else begin
      case (s1_read_size)
        READ_DISABLE:  wb_value = '0;
        READ_BYTE:     wb_value = {{(NB_DATA-8){byte_sign}}, i_mem_data[7:0]};
        READ_HALFWORD: wb_value = {{(NB_DATA-16){half_sign}}, i_mem_data[15:0]};
        READ_WORD:     wb_value = i_mem_data;
        default:       wb_value = '0;
      endcase
    end
  end

  // S1: control capture; flush overrides stall
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid       <= 1'b0;
      s1_alu_result  <= '0;
      s1_rd          <= '0;
      s1_reg_write   <= 1'b0;
      s1_mem_to_reg  <= 1'b0;
      s1_read_size   <= READ_DISABLE;
      s1_load_signed <= 1'b0;
    end else begin
      if (i_flush) begin
        s1_valid <= 1'b0;
      end else if (!i_stall) begin
        s1_valid <= i_valid;
      end
      if (!i_stall) begin
        s1_alu_result  <= i_alu_result;
        s1_rd          <= i_rd;
        s1_reg_write   <= i_reg_write;
        s1_mem_to_reg  <= i_mem_to_reg;
        s1_read_size   <= i_read_size;
        s1_load_signed <= i_load_signed;
      end
    end
  end

  // S2: write-back bundle, zeroed whenever it carries no instruction
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_wb_valid     <= 1'b0;
      o_wb_data      <= '0;
      o_wb_rd        <= '0;
      o_wb_reg_write <= 1'b0;
    end else if (!i_stall) begin
      o_wb_valid     <= s1_live;
      o_wb_data      <= s1_live ? wb_value : '0;
      o_wb_rd        <= s1_live ? s1_rd : '0;
      o_wb_reg_write <= s1_live & s1_reg_write;
    end
  end

  assign o_fwd_busy = s1_valid & s1_mem_to_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_mem_wb_stage;
  localparam int unsigned NB_DATA = 32;
  localparam int unsigned NB_REG  = 5;
`ifdef LOAD_SIGN_EXT_EN
  localparam bit SEXT_EN = 1'b1;
`else
  localparam bit SEXT_EN = 1'b0;
`endif

  logic               i_clk = 1'b0;
  logic               i_rst = 1'b1;
  logic               i_valid = 1'b0;
  logic [NB_DATA-1:0] i_alu_result = '0;
  logic [NB_REG-1:0]  i_rd = '0;
  logic               i_reg_write = 1'b0;
  logic               i_mem_to_reg = 1'b0;
  logic [1:0]         i_read_size = 2'd0;
  logic               i_load_signed = 1'b0;
  logic [NB_DATA-1:0] i_mem_data = '0;
  logic               i_stall = 1'b0;
  logic               i_flush = 1'b0;
  logic               o_wb_valid;
  logic [NB_DATA-1:0] o_wb_data;
  logic [NB_REG-1:0]  o_wb_rd;
  logic               o_wb_reg_write;
  logic               o_fwd_busy;

  int n_checks = 0;
  int n_fail = 0;

  mem_wb_stage #(.NB_DATA(NB_DATA), .NB_REG(NB_REG)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_alu_result(i_alu_result),
    .i_rd(i_rd), .i_reg_write(i_reg_write), .i_mem_to_reg(i_mem_to_reg),
    .i_read_size(i_read_size), .i_load_signed(i_load_signed), .i_mem_data(i_mem_data),
    .i_stall(i_stall), .i_flush(i_flush), .o_wb_valid(o_wb_valid), .o_wb_data(o_wb_data),
    .o_wb_rd(o_wb_rd), .o_wb_reg_write(o_wb_reg_write), .o_fwd_busy(o_fwd_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Value a load or ALU op writes back, from the load rules in plain arithmetic
  function automatic logic [31:0] expect_wb(input bit m2r, input logic [1:0] size,
                                            input bit sgn, input logic [31:0] alu,
                                            input logic [31:0] mem);
    logic [7:0]  b;
    logic [15:0] h;
    b = mem[7:0];
    h = mem[15:0];
    if (!m2r) return alu;
    case (size)
      2'd3: return mem;
      2'd2: return (sgn && SEXT_EN) ? 32'($signed(h)) : 32'(h);
      2'd1: return (sgn && SEXT_EN) ? 32'($signed(b)) : 32'(b);
      default: return 32'd0;
    endcase
  endfunction

  // Model: the one instruction awaiting write-back and the currently expected result
  typedef struct packed {
    logic        v;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        we;
    logic        m2r;
    logic [1:0]  size;
    logic        sgn;
  } instr_t;

  instr_t      pending;
  logic        m_valid;
  logic [31:0] m_data;
  logic [4:0]  m_rd;
  logic        m_we;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pending = '0;
      m_valid = 1'b0; m_data = '0; m_rd = '0; m_we = 1'b0;
    end else if (!i_stall) begin
      if (pending.v && !i_flush) begin
        m_valid = 1'b1;
        m_data  = expect_wb(pending.m2r, pending.size, pending.sgn, pending.alu, i_mem_data);
        m_rd    = pending.rd;
        m_we    = pending.we;
      end else begin
        m_valid = 1'b0; m_data = '0; m_rd = '0; m_we = 1'b0;
      end
      pending.v    = i_valid && !i_flush;
      pending.alu  = i_alu_result;
      pending.rd   = i_rd;
      pending.we   = i_reg_write;
      pending.m2r  = i_mem_to_reg;
      pending.size = i_read_size;
      pending.sgn  = i_load_signed;
    end else if (i_flush) begin
      pending.v = 1'b0;
    end
  end

  always @(negedge i_clk) begin
    check("wb_valid", 32'(o_wb_valid), 32'(m_valid));
    check("wb_data", o_wb_data, m_data);
    check("wb_rd", 32'(o_wb_rd), 32'(m_rd));
    check("wb_reg_write", 32'(o_wb_reg_write), 32'(m_we));
    check("fwd_busy", 32'(o_fwd_busy), 32'(pending.v && pending.m2r));
  end

  task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] rdv,
                       input logic we, input logic m2r, input logic [1:0] sz, input logic sg,
                       input logic [31:0] mem, input logic st, input logic fl);
    i_valid = v; i_alu_result = alu; i_rd = rdv; i_reg_write = we; i_mem_to_reg = m2r;
    i_read_size = sz; i_load_signed = sg; i_mem_data = mem; i_stall = st; i_flush = fl;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic idle(input logic [31:0] mem);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, mem, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge i_clk);
    check("reset_wb_valid", 32'(o_wb_valid), 32'd0);
    check("reset_fwd_busy", 32'(o_fwd_busy), 32'd0);
    i_rst = 1'b0;
    idle(32'h0);

    // ALU op
    drive(1'b1, 32'h0000_1234, 5'd3, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("alu_valid_early", 32'(o_wb_valid), 32'd0);
    idle(32'hCAFE_0000);
    check("alu_valid", 32'(o_wb_valid), 32'd1);
    check("alu_data", o_wb_data, 32'h0000_1234);
    check("alu_rd", 32'(o_wb_rd), 32'd3);

    // Signed byte load
    drive(1'b1, 32'h40, 5'd5, 1'b1, 1'b1, 2'd1, 1'b1, 32'h0, 1'b0, 1'b0);
    check("lb_fwd_busy", 32'(o_fwd_busy), 32'd1);
    idle(32'h0000_0080);
    check("lb_data", o_wb_data, SEXT_EN ? 32'hFFFF_FF80 : 32'h0000_0080);

    // Unsigned halfword load
    drive(1'b1, 32'h44, 5'd6, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(32'h0000_8001);
    check("lhu_data", o_wb_data, 32'h0000_8001);

    // Stall for 3 cycles with a load in S1 and an ALU result in S2
    drive(1'b1, 32'h55, 5'd7, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h100, 5'd9, 1'b1, 1'b1, 2'd3, 1'b0, 32'h1111_1111, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, 5'd30, 1'b1, 1'b1, 2'd1, 1'b1, $urandom, 1'b1, 1'b0);
      check("stall_data", o_wb_data, 32'h55);
      check("stall_rd", 32'(o_wb_rd), 32'd7);
      check("stall_fwd_busy", 32'(o_fwd_busy), 32'd1);
    end
    idle(32'hDEAD_BEEF);
    check("stall_release_data", o_wb_data, 32'hDEAD_BEEF);
    check("stall_release_rd", 32'(o_wb_rd), 32'd9);

    // Flush together with stall kills the load in S1
    drive(1'b1, 32'h200, 5'd11, 1'b1, 1'b1, 2'd1, 1'b0, 32'h0, 1'b0, 1'b0);
    check("flush_pre_busy", 32'(o_fwd_busy), 32'd1);
    drive(1'b1, 32'h300, 5'd12, 1'b1, 1'b1, 2'd1, 1'b0, 32'h7F, 1'b1, 1'b1);
    check("flush_busy", 32'(o_fwd_busy), 32'd0);
    idle(32'h7F);
    check("flush_no_wb_1", 32'(o_wb_valid), 32'd0);
    idle(32'h7F);
    check("flush_no_wb_2", 32'(o_wb_valid), 32'd0);

    // Asynchronous reset between two in-flight instructions
    drive(1'b1, 32'hAAAA, 5'd12, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'hBBBB, 5'd13, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("pre_reset_valid", 32'(o_wb_valid), 32'd1);
    #2 i_rst = 1'b1;
    #1 check("async_reset_valid", 32'(o_wb_valid), 32'd0);
    check("async_reset_busy", 32'(o_fwd_busy), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    idle(32'h0);
    check("post_reset_wb_1", 32'(o_wb_valid), 32'd0);
    idle(32'h0);
    check("post_reset_wb_2", 32'(o_wb_valid), 32'd0);
    drive(1'b1, 32'h77, 5'd1, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("post_reset_latency_1", 32'(o_wb_valid), 32'd0);
    idle(32'h0);
    check("post_reset_latency_2", 32'(o_wb_valid), 32'd1);
    check("post_reset_data", o_wb_data, 32'h77);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      i_rst = ($urandom_range(0, 299) == 0);
      drive(($urandom_range(0, 9) < 7), $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
            2'($urandom), 1'($urandom), $urandom,
            ($urandom_range(0, 9) < 2), ($urandom_range(0, 99) < 8));
    end
    i_rst = 1'b0;
    idle(32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
